hazard_ctrl_unit: RTL

//  Parametrised pipeline hazard controller for the MIPS core, sitting beside the ID stage.

---
 rtl/hazard_ctrl_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// Load-use / taken-branch hazard controller beside the ID stage.
// Drives stall/bubble/flush for the pipeline registers and keeps saturating event counters.

module hazard_src_cmp #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              vld,
    input  logic [REG_AW-1:0] dst,
    output logic              hit
);
    assign hit = vld && (src == dst);
endmodule

module hazard_ctrl_unit #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = 1,
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_vld,
    input  logic [REG_AW-1:0]         ex_dst,
    input  logic                      ex_mem_read,
    input  logic                      br_taken,
    output logic                      stall,
    output logic                      bubble,
    output logic                      flush,
    output logic                      busy,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);
    typedef enum logic [1:0] {IDLE, LSTALL, FLUSH} state_t;

    localparam int REM_W = 4;
    localparam logic [REM_W-1:0] LD_RELOAD = REM_W'(LOAD_LAT - 1);
    localparam logic [REM_W-1:0] BR_RELOAD = REM_W'(BR_PENALTY - 1);

    state_t             state, state_nxt;
    logic [REM_W-1:0]   rem, rem_nxt;
    logic [NUM_SRC-1:0] src_hit;
    logic               hit;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        hazard_src_cmp #(.REG_AW(REG_AW)) u_cmp (
            .src (id_src[g*REG_AW +: REG_AW]),
            .vld (id_src_vld[g]),
            .dst (ex_dst),
            .hit (src_hit[g])
        );
    end

    // r0 is hardwired zero, so a load targeting it can never create a dependency
    assign hit = ex_mem_read && (ex_dst != '0) && (|src_hit);

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        stall     = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        if (br_taken) begin
            flush = 1'b1;
            if (BR_PENALTY > 1) begin
                state_nxt = FLUSH;
                rem_nxt   = BR_RELOAD;
            end else begin
                state_nxt = IDLE;
                rem_nxt   = '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_nxt = LSTALL;
                            rem_nxt   = LD_RELOAD;
                        end
                    end
                end
                LSTALL: begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    rem_nxt = rem - 1'b1;
                    if (rem == 1) state_nxt = IDLE;
                end
                FLUSH: begin
                    flush   = 1'b1;
                    rem_nxt = rem - 1'b1;
                    if (rem == 1) state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    rem_nxt   = '0;
                end
            endcase
        end
        // held-in-reset pipeline must see no control activity
        if (!rst_n) begin
            stall  = 1'b0;
            bubble = 1'b0;
            flush  = 1'b0;
        end
    end

    assign busy = rst_n && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule
